// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-cycle issue controller that decodes instructions,
// feeds an external ALU from an 8-entry register file and writes results back.
module alu_issue_ctrl #(
   parameter int NREGS = 8,
   parameter int IMM_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic [2:0]  ALUop,
   output logic [31:0] A,
   output logic [31:0] B,
   input  logic [31:0] Result,
   output logic        done,
   output logic [31:0] wb_data,
   output logic        illegal,
   input  logic [2:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXECUTE, S_WRITEBACK} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [31:0]       r_ir;
   logic [31:0]       r_a;
   logic [31:0]       r_b;
   logic [31:0]       r_res;
   logic [2:0]        r_op;
   logic [31:0]       r_regs [NREGS];

   logic [3:0]        w_opcode;
   logic [2:0]        w_rd;
   logic [2:0]        w_rs1;
   logic [2:0]        w_rs2;
   logic [IMM_W-1:0]  w_imm;
   logic [2:0]        w_aluop;
   logic              w_isImm;
   logic              w_writable;
   logic              w_illegal;
   logic              w_unused;

   assign w_opcode  = r_ir[31:28];
   assign w_rd      = r_ir[27:25];
   assign w_rs1     = r_ir[24:22];
   assign w_rs2     = r_ir[21:19];
   assign w_imm     = r_ir[IMM_W-1:0];
   assign w_unused  = ^r_ir[18:16];
   assign w_illegal = (w_opcode > 4'h6);

   // Opcode decode; NOP and illegal opcodes map to ALUop 000 and never write.
   always_comb begin
      w_aluop    = 3'b000;
      w_isImm    = 1'b0;
      w_writable = 1'b0;
      case (w_opcode)
         4'h1: begin w_aluop = 3'b010; w_writable = 1'b1; end
         4'h2: begin w_aluop = 3'b011; w_writable = 1'b1; end
         4'h3: begin w_aluop = 3'b100; w_writable = 1'b1; end
         4'h4: begin w_aluop = 3'b101; w_writable = 1'b1; end
         4'h5: begin w_aluop = 3'b110; w_writable = 1'b1; w_isImm = 1'b1; end
         4'h6: begin w_aluop = 3'b111; w_writable = 1'b1; w_isImm = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (instr_valid) w_next = S_DECODE;
         S_DECODE:    w_next = S_EXECUTE;
         S_EXECUTE:   w_next = S_WRITEBACK;
         S_WRITEBACK: w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ir  <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_op  <= '0;
         r_res <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (instr_valid) r_ir <= instr;
            S_DECODE: begin
               r_a  <= r_regs[w_rs1];
               r_b  <= w_isImm ? {{(32-IMM_W){1'b0}}, w_imm} : r_regs[w_rs2];
               r_op <= w_aluop;
            end
            S_EXECUTE: r_res <= w_writable ? Result : 32'h0;
            default: ;
         endcase
      end
   end

   // Entry 0 is never written, so it reads as zero without a special read path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (r_state == S_WRITEBACK && w_writable && w_rd != 3'd0) begin
         r_regs[w_rd] <= r_res;
      end
   end

   assign instr_ready = rst_n && (r_state == S_IDLE);
   assign ALUop       = (r_state == S_EXECUTE) ? r_op : 3'b000;
   assign A           = (r_state == S_EXECUTE) ? r_a  : 32'h0;
   assign B           = (r_state == S_EXECUTE) ? r_b  : 32'h0;
   assign done        = (r_state == S_WRITEBACK);
   assign wb_data     = done ? r_res : 32'h0;
   assign illegal     = done && w_illegal;
   assign dbg_data    = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against
// an instruction-level register-file model, with a stand-in ALU.
module tb_alu_issue_ctrl;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [2:0]  ALUop;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] Result;
   logic        done;
   logic [31:0] wb_data;
   logic        illegal;
   logic [2:0]  dbg_addr;
   logic [31:0] dbg_data;

   int          checkCount = 0;
   int          passCount  = 0;
   logic [31:0] modelRegs [8];

   alu_issue_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .ALUop(ALUop), .A(A), .B(B), .Result(Result), .done(done),
      .wb_data(wb_data), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stand-in for the downstream alu block.
   always_comb begin
      case (ALUop)
         3'b010, 3'b110: Result = A + B;
         3'b011:         Result = {31'b0, A == B};
         3'b100:         Result = A << B;
         3'b101:         Result = A >> B;
         3'b111:         Result = A - B;
         default:        Result = 32'h0;
      endcase
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] mk(input int opc, input int rd, input int rs1,
                                      input int rs2, input int imm);
      logic [31:0] w;
      w = {opc[3:0], rd[2:0], rs1[2:0], rs2[2:0], 3'b000, imm[15:0]};
      return w;
   endfunction

   function automatic logic [2:0] expectedAluop(input logic [3:0] opc);
      case (opc)
         4'h1: return 3'b010;
         4'h2: return 3'b011;
         4'h3: return 3'b100;
         4'h4: return 3'b101;
         4'h5: return 3'b110;
         4'h6: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [31:0] refResult(input logic [3:0] opc, input logic [31:0] a,
                                             input logic [31:0] b);
      longint unsigned s;
      case (opc)
         4'h1, 4'h5: begin s = longint'(a) + longint'(b); return s[31:0]; end
         4'h2: return (a == b) ? 32'd1 : 32'd0;
         4'h3: return (b >= 32) ? 32'd0 : 32'(a * (32'd1 << b[4:0]));
         4'h4: return (b >= 32) ? 32'd0 : 32'(a / (32'd1 << b[4:0]));
         4'h6: begin s = longint'(a) + 64'h1_0000_0000 - longint'(b); return s[31:0]; end
         default: return 32'd0;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic checkAllDbg(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         @(posedge clk); #1;
         checkOutput($sformatf("%s_dbg_r%0d", tag, i), dbg_data, modelRegs[i]);
      end
   endtask

   // Issues one instruction from IDLE and checks every cycle until it retires.
   task automatic applyStimulus(input logic [31:0] ins);
      logic [3:0]  opc;
      logic [2:0]  rd, rs1, rs2;
      logic [31:0] a, b, res;
      logic        legal, writes;
      opc    = ins[31:28];
      rd     = ins[27:25];
      rs1    = ins[24:22];
      rs2    = ins[21:19];
      legal  = (opc <= 4'h6);
      writes = legal && (opc != 4'h0);
      a      = modelRegs[rs1];
      b      = (opc == 4'h5 || opc == 4'h6) ? {16'h0, ins[15:0]} : modelRegs[rs2];
      res    = writes ? refResult(opc, a, b) : 32'h0;

      checkOutput("ready_idle", {31'b0, instr_ready}, 32'd1);
      instr       = ins;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      checkOutput("ready_decode", {31'b0, instr_ready}, 32'd0);
      checkOutput("done_decode", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
      checkOutput("aluop_exec", {29'b0, ALUop}, {29'b0, expectedAluop(opc)});
      if (writes) begin
         checkOutput("a_exec", A, a);
         checkOutput("b_exec", B, b);
      end
      @(posedge clk); #1;
      checkOutput("done_wb", {31'b0, done}, 32'd1);
      checkOutput("illegal_wb", {31'b0, illegal}, {31'b0, ~legal});
      checkOutput("wbdata_wb", wb_data, res);
      @(posedge clk); #1;
      checkOutput("done_after", {31'b0, done}, 32'd0);
      checkOutput("wbdata_after", wb_data, 32'd0);
      if (writes && rd != 3'd0) modelRegs[rd] = res;
      dbg_addr = rd;
      #1;
      checkOutput($sformatf("dbg_rd%0d", rd), dbg_data, modelRegs[rd]);
   endtask

   initial begin
      logic        doneSeen;
      int          accepts;
      logic [31:0] r1Start;
      logic [31:0] ins;

      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = 32'h0;
      dbg_addr    = 3'd0;
      for (int i = 0; i < 8; i++) modelRegs[i] = 32'h0;

      // Power-on reset
      #1;
      checkOutput("rst_ready", {31'b0, instr_ready}, 32'd0);
      checkOutput("rst_done", {31'b0, done}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("post_rst_ready", {31'b0, instr_ready}, 32'd1);
      checkAllDbg("post_rst");

      // Reset asserted mid-EXECUTE aborts the instruction
      instr       = mk(5, 1, 0, 0, 16'h0005);
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort_b_exec", B, 32'd5);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_ready", {31'b0, instr_ready}, 32'd0);
      checkOutput("abort_a", A, 32'd0);
      checkOutput("abort_b", B, 32'd0);
      checkOutput("abort_aluop", {29'b0, ALUop}, 32'd0);
      checkOutput("abort_done", {31'b0, done}, 32'd0);
      checkOutput("abort_illegal", {31'b0, illegal}, 32'd0);
      checkOutput("abort_wbdata", wb_data, 32'd0);
      doneSeen = 1'b0;
      repeat (3) begin @(negedge clk); if (done) doneSeen = 1'b1; end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) begin @(negedge clk); if (done) doneSeen = 1'b1; end
      checkOutput("abort_no_done", {31'b0, doneSeen}, 32'd0);
      @(posedge clk); #1;
      checkOutput("abort_ready_after", {31'b0, instr_ready}, 32'd1);
      checkAllDbg("post_abort");

      // ADDI, ADDI, ADD with exact-latency checks inside applyStimulus
      applyStimulus(mk(5, 1, 0, 0, 16'h0005));
      applyStimulus(mk(5, 2, 0, 0, 16'h0007));
      applyStimulus(mk(1, 3, 1, 2, 0));
      checkOutput("add_r3_is_12", modelRegs[3] ^ dbg_data, 32'd0);

      // EQ and shifts, including an out-of-range shift amount
      applyStimulus(mk(5, 2, 0, 0, 5));
      applyStimulus(mk(2, 4, 1, 2, 0));
      applyStimulus(mk(5, 2, 0, 0, 3));
      applyStimulus(mk(3, 5, 1, 2, 0));
      applyStimulus(mk(4, 6, 5, 2, 0));
      applyStimulus(mk(5, 7, 0, 0, 33));
      applyStimulus(mk(3, 4, 1, 7, 0));

      // SUBI wrap-around and carry drop
      applyStimulus(mk(6, 1, 0, 0, 1));
      applyStimulus(mk(5, 1, 1, 0, 1));

      // Illegal opcode and r0 protection
      applyStimulus(mk(10, 3, 1, 2, 16'h1234));
      applyStimulus(mk(5, 0, 0, 0, 9));
      checkAllDbg("after_illegal");

      // Back-pressure: valid held high with one constant instruction
      r1Start     = modelRegs[1];
      accepts     = 0;
      instr       = mk(5, 1, 1, 0, 1);
      instr_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
         checkOutput($sformatf("bp_ready_c%0d", c), {31'b0, instr_ready},
                     {31'b0, (c % 4) == 0});
         if (instr_ready) accepts++;
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      checkOutput("bp_accepts", 32'(accepts), 32'd4);
      modelRegs[1] = r1Start + 32'd4;
      dbg_addr = 3'd1;
      #1;
      checkOutput("bp_final_r1", dbg_data, modelRegs[1]);
      @(posedge clk); #1;

      // Randomized instructions against the model
      for (int n = 0; n < 24; n++) begin
         ins = mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40))
                                              : int'($urandom_range(0, 65535)));
         applyStimulus(ins);
      end
      checkAllDbg("final");

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
